// File: rtl/serial_borrow_subtractor.sv
// Bit-serial ripple-borrow subtractor: D = a - b - bin, one bit per clock, LSB first.
// Per-bit borrows are exposed on Bout, mirroring the ripple-carry adder's carry vector.
module serial_borrow_subtractor #(
    parameter int unsigned SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            bin,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] D,
    output logic [SIZE-1:0] Bout,
    output logic            bout
);

    localparam int unsigned     IdxW    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(SIZE - 1);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e          state;
    logic [SIZE-1:0] ra;
    logic [SIZE-1:0] rb;
    logic            br;
    logic [IdxW-1:0] idx;

    logic x;
    logic y;
    logic diff;
    logic nb;

    // Full-subtractor cell for the bit currently selected by idx.
    always_comb begin
        x    = ra[idx];
        y    = rb[idx];
        diff = x ^ y ^ br;
        nb   = (~x & y) | (~x & br) | (y & br);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            ra    <= '0;
            rb    <= '0;
            br    <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            D     <= '0;
            Bout  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        br    <= bin;
                        idx   <= '0;
                        D     <= '0;
                        Bout  <= '0;
                        busy  <= 1'b1;
                        state <= StRun;
                    end
                end
                StRun: begin
                    D[idx]    <= diff;
                    Bout[idx] <= nb;
                    br        <= nb;
                    idx       <= idx + 1'b1;
                    if (idx == LastIdx) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bout = Bout[SIZE-1];

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Bench for serial_borrow_subtractor: arithmetic reference model checked every cycle on a
// SIZE=4 instance, plus directed literal checks and random operations on SIZE=1 and SIZE=8.
module tb_serial_borrow_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [3:0] D;
    logic [3:0] Bout;
    logic       bout;

    logic       s1, a1, b1, bin1, busy1, done1, D1, Bout1, bout1;
    logic       s8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, D8, Bout8;

    int total = 0;
    int bad   = 0;
    int lat;

    serial_borrow_subtractor #(.SIZE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .D(D), .Bout(Bout), .bout(bout)
    );

    serial_borrow_subtractor #(.SIZE(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .D(D1), .Bout(Bout1), .bout(bout1)
    );

    serial_borrow_subtractor #(.SIZE(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .D(D8), .Bout(Bout8), .bout(bout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference arithmetic: bit i borrows out exactly when the low i+1 bits of a are
    // smaller than the low i+1 bits of b plus the borrow-in.
    function automatic logic [3:0] ref_diff(input int av, input int bv, input int bi);
        return 4'((av - bv - bi) & 15);
    endfunction

    function automatic logic [3:0] ref_borrows(input int av, input int bv, input int bi);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            int m;
            m    = (1 << (i + 1)) - 1;
            r[i] = ((av & m) < ((bv & m) + bi));
        end
        return r;
    endfunction

    // Cycle-level expectation: after k bits of a run, only the low k result bits are valid.
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [3:0] m_D    = '0;
    logic [3:0] m_Bout = '0;
    logic [3:0] e_D    = '0;
    logic [3:0] e_B    = '0;
    int         m_k    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_D    = '0;
            m_Bout = '0;
            m_k    = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_k++;
                m_D    = 4'(int'(e_D) & ((1 << m_k) - 1));
                m_Bout = 4'(int'(e_B) & ((1 << m_k) - 1));
                if (m_k == 4) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (start) begin
                e_D    = ref_diff(int'(a), int'(b), int'(bin));
                e_B    = ref_borrows(int'(a), int'(b), int'(bin));
                m_busy = 1'b1;
                m_k    = 0;
                m_D    = '0;
                m_Bout = '0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", busy, m_busy);
        chk("cyc_done", done, m_done);
        chk("cyc_D", D, m_D);
        chk("cyc_Bout", Bout, m_Bout);
        chk("cyc_bout", bout, m_Bout[3]);
    end

    task automatic wait_done(inout int l);
        do begin
            @(posedge clk);
            l++;
            #1;
        end while (!done && l < 20);
    endtask

    task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input logic bi,
                          output int l);
        @(posedge clk);
        #2;
        a     = av;
        b     = bv;
        bin   = bi;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        l     = 0;
        wait_done(l);
    endtask

    task automatic rand_op(input int sz);
        logic [7:0] av, bv, ev, dv;
        logic       bi, eb, bo, dn;
        int         mask, l;
        mask = (1 << sz) - 1;
        av   = 8'($urandom & mask);
        bv   = 8'($urandom & mask);
        bi   = 1'($urandom_range(0, 1));
        ev   = 8'((int'(av) - int'(bv) - int'(bi)) & mask);
        eb   = (int'(av) < int'(bv) + int'(bi));
        @(posedge clk);
        #2;
        if (sz == 1) begin
            a1 = av[0]; b1 = bv[0]; bin1 = bi; s1 = 1'b1;
        end else begin
            a8 = av; b8 = bv; bin8 = bi; s8 = 1'b1;
        end
        @(posedge clk);
        #2;
        s1 = 1'b0;
        s8 = 1'b0;
        l  = 0;
        do begin
            @(posedge clk);
            l++;
            #1;
            dn = (sz == 1) ? done1 : done8;
        end while (!dn && l < 20);
        dv = (sz == 1) ? {7'b0, D1} : D8;
        bo = (sz == 1) ? bout1 : bout8;
        chk("rand_latency", l, sz);
        chk("rand_D", dv, ev);
        chk("rand_bout", bo, eb);
        @(posedge clk);
        #1;
        dn = (sz == 1) ? done1 : done8;
        chk("rand_done_width", dn, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0; a = '0; b = '0; bin = 1'b0;
        s1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
        s8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_D", D, 4'd0);
        chk("reset_Bout", Bout, 4'd0);

        run_op(4'd9, 4'd3, 1'b0, lat);
        chk("pos_latency", lat, 4);
        chk("pos_D", D, 4'b0110);
        chk("pos_Bout", Bout, 4'b0110);
        chk("pos_bout", bout, 1'b0);

        run_op(4'd3, 4'd9, 1'b0, lat);
        chk("wrap_D", D, 4'b1010);
        chk("wrap_Bout", Bout, 4'b1000);
        chk("wrap_bout", bout, 1'b1);

        run_op(4'd0, 4'd0, 1'b1, lat);
        chk("bprop_D", D, 4'b1111);
        chk("bprop_Bout", Bout, 4'b1111);
        chk("bprop_bout", bout, 1'b1);

        run_op(4'd15, 4'd15, 1'b0, lat);
        chk("eq_D", D, 4'd0);
        chk("eq_Bout", Bout, 4'd0);
        chk("eq_bout", bout, 1'b0);

        // Start while busy is ignored; start in the done cycle is accepted.
        @(posedge clk);
        #2 a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        @(posedge clk);
        #2 a = 4'd1; b = 4'd1; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        lat = 2;
        wait_done(lat);
        chk("ign_latency", lat, 4);
        chk("ign_D", D, 4'd6);
        a = 4'd5; b = 4'd2; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_busy", busy, 1'b1);
        start = 1'b0;
        lat = 0;
        wait_done(lat);
        chk("b2b_latency", lat, 4);
        chk("b2b_D", D, 4'd3);

        // Asynchronous reset in the middle of a run.
        @(posedge clk);
        #2 a = 4'd12; b = 4'd5; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_D", D, 4'd0);
        chk("arst_Bout", Bout, 4'd0);
        chk("arst_bout", bout, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (6) @(posedge clk);
        run_op(4'd9, 4'd3, 1'b0, lat);
        chk("post_rst_latency", lat, 4);
        chk("post_rst_D", D, 4'd6);

        // Free-running random stimulus; the per-cycle model decides what is accepted.
        repeat (4000) begin
            @(posedge clk);
            #2;
            a     = 4'($urandom);
            b     = 4'($urandom);
            bin   = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
        end
        #0 start = 1'b0;
        repeat (6) @(posedge clk);

        repeat (1000) rand_op(1);
        repeat (1000) rand_op(8);

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_borrow_subtractor.md
# serial_borrow_subtractor

Bit-serial ripple-borrow subtractor that computes `D = a - b - bin` one bit per clock, LSB first. It is the subtract-direction counterpart to the combinational ripple-carry adder datapath. Operands are captured on a single-cycle `start`, and completion is flagged with a one-cycle `done`. It is used where area matters more than latency: each per-bit borrow is exposed as a vector, mirroring the adder's per-bit carry vector.

## Interface
- `SIZE`, default 4: operand and result width in bits; legal range is 1 or more.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request. Sampled only when the block is idle.
- `a`  in  SIZE: minuend; captured with `start`.
- `b`  in  SIZE: subtrahend; captured with `start`.
- `bin`  in  1: borrow-in; captured with `start`.
- `busy`  out  1: high while an operation is in progress.
- `done`  out  1: one-cycle pulse when the result is complete.
- `D`  out  SIZE: difference, registered.
- `Bout`  out  SIZE: per-bit borrow-out. `Bout[i]` is the borrow leaving bit `i`.
- `bout`  out  1: final borrow, equal to `Bout[SIZE-1]`.

## Operation
- **States:** IDLE and RUN. Internal registers:
  - `ra`, `rb`: operand copies.
  - `br`: running borrow.
  - `idx`: bit index, width `$clog2(SIZE)`, minimum 1.
- **IDLE with `start`=1:**
  - Capture `ra`=`a`, `rb`=`b`, `br`=`bin`, `idx`=0.
  - Clear `D` and `Bout` to 0.
  - Set `busy`=1 and go to RUN.
- **IDLE with `start`=0:** hold all outputs.
- **RUN, each cycle** with `x`=`ra[idx]`, `y`=`rb[idx]`:
  - `D[idx]` <= `x ^ y ^ br`.
  - `Bout[idx]` and `br` <= `(~x & y) | (~x & br) | (y & br)`.
  - `idx` <= `idx + 1`.
- **RUN, when `idx` == SIZE-1:** after this bit's update, go to IDLE with `busy`<=0 and `done`<=1.
- **`done`:** high for exactly one cycle; otherwise 0.
- **`start` while RUN:** ignored. No queuing; operands and result are unaffected.
- **`start` while `done`=1:** the block is already IDLE, so the start is accepted. This gives back-to-back operation with no gap cycle.
- **Result hold:** `D`, `Bout` and `bout` hold their final value until the next accepted `start`.
- **Arithmetic:** `D` is `(a - b - bin) mod 2^SIZE`. `bout`=1 exactly when `a < b + bin` as unsigned numbers.
- **Input stability:** `a`, `b` and `bin` may change freely after capture.

## Timing
- **Reset (asynchronous, immediate):**
  - `busy`=0, `done`=0, `D`=0, `Bout`=0, `bout`=0.
  - State IDLE; `idx`, `br`, `ra` and `rb` = 0.
- **Reset mid-operation:** the operation is abandoned. No `done` is issued and the outputs go to their reset values.
- **Cycle numbering:** `start` is sampled at edge E0, giving `busy`=1 after E0. Bit `i` is written at edge E(i+1).
- **Completion:** at edge E(SIZE), `D` is final, `busy`=0 and `done`=1. `done` falls at E(SIZE+1) unless a new operation completes then.
- **Latency:** SIZE cycles from the `start` edge to `done` high.
- **Throughput:** one result per SIZE cycles when `start` is asserted back-to-back.
- **SIZE=1:** a single RUN cycle; `done` is high after E1.
- **Partial results:** `D` is partially valid during RUN. Bits at or above `idx` read 0. Consumers use `D` only when `done`=1.

## Test plan
1. **Positive result.** SIZE=4: `a`=9, `b`=3, `bin`=0, then `start`. Required response:
   - `done` high after 4 cycles.
   - `D`=6 (0110), `Bout`=0110, `bout`=0.
2. **Wrap-around.** `a`=3, `b`=9, `bin`=0. Required response:
   - `D`=10 (1010), `Bout`=1000, `bout`=1.
3. **Borrow propagation.**
   - `a`=0, `b`=0, `bin`=1 -> `D`=1111, `Bout`=1111, `bout`=1.
   - `a`=15, `b`=15, `bin`=0 -> `D`=0, `Bout`=0, `bout`=0.
4. **Start handling.**
   - Assert `start` with new operands (`a`=1, `b`=1) in cycle 2 of a busy operation: it is ignored, and the first result is unchanged.
   - Assert `start` again in the `done` cycle with `a`=5, `b`=2: `busy` stays high, and the second `done` arrives 4 cycles later with `D`=3.
5. **Reset handling.**
   - Assert `rst` asynchronously mid-RUN: `busy`, `done`, `D` and `Bout` go to 0 immediately, with no `done` pulse.
   - A later `start` with `a`=9, `b`=3 completes normally with `D`=6.
6. **Randomised check.** Run 1000 random `a`, `b`, `bin` operations for SIZE=1, 4 and 8. Required response:
   - `D` equals `(a-b-bin) mod 2^SIZE`.
   - `bout` equals `(a < b+bin)`.
   - `done` is exactly one cycle wide, and latency equals SIZE.
